// File: rtl/guia04_pkg.sv
// Shared definitions for the Guia_04 truth-table capture blocks: FSM state
// encoding, default function width and the truth-table width helper.
package guia04_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_VARS_DEF = 4;

    // Number of rows in the truth table of an n-input function.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/maxterm_scanner_next_zero.sv
// tt_next_zero: combinational "is there any zero bit above ptr" detector.
// The scanner uses it to tell whether the index currently offered is the
// final one in the list.
module tt_next_zero
    import guia04_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic [tt_width(N_VARS)-1:0] tbl_i,
    input  logic [N_VARS-1:0]           ptr_i,
    output logic                        zero_above_o
);

    localparam int TT_W = tt_width(N_VARS);

    logic [TT_W-1:0] above_mask;

    // Thermometer mask selecting every row strictly above ptr.
    for (genvar gi = 0; gi < TT_W; gi++) begin : g_mask
        localparam logic [N_VARS-1:0] GI_IDX = N_VARS'(gi);
        assign above_mask[gi] = (GI_IDX > ptr_i);
    end

    assign zero_above_o = |(~tbl_i & above_mask);

endmodule

// File: rtl/maxterm_scanner.sv
// maxterm_scanner: drives every input combination of an N_VARS-input
// function in ascending order, captures the truth table, then streams the
// maxterm index list over a valid/ready handshake.
// Build option: define MAXTERM_SCANNER_MINTERM_EN to stream and count the
// rows where the function is 1 (minterm list) instead of the rows where it
// is 0. The captured table is the same in both builds.
module maxterm_scanner
    import guia04_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic [N_VARS-1:0]           vec_out,
    input  logic                        s_in,
    output logic [tt_width(N_VARS)-1:0] table_out,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [N_VARS-1:0]           m_index,
    output logic                        m_last,
    output logic [N_VARS:0]             m_count,
    output logic                        done
);

    localparam int                TT_W        = tt_width(N_VARS);
    localparam logic [N_VARS-1:0] LAST_IDX    = N_VARS'(TT_W - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE);
`ifdef MAXTERM_SCANNER_MINTERM_EN
    localparam logic              TARGET      = 1'b1;
`else
    localparam logic              TARGET      = 1'b0;
`endif

    state_t            state_q;
    logic [N_VARS-1:0] idx_q;
    logic [N_VARS-1:0] ptr_q;
    logic [3:0]        settle_q;
    logic [TT_W-1:0]   table_q;
    logic [N_VARS:0]   count_q;
    logic              busy_q;
    logic              done_q;

    logic              hit;
    logic              ptr_adv;
    logic              target_above;
    logic [TT_W-1:0]   search_tbl;

    // Rows of interest become zeros in search_tbl so one detector serves
    // both the maxterm and the minterm build.
    assign search_tbl = table_q ^ {TT_W{TARGET}};
    assign hit        = (table_q[ptr_q] == TARGET);
    // Non-target rows are skipped in one cycle; target rows wait for ready.
    assign ptr_adv    = !hit || m_ready;

    tt_next_zero #(
        .N_VARS (N_VARS)
    ) u_next_zero (
        .tbl_i        (search_tbl),
        .ptr_i        (ptr_q),
        .zero_above_o (target_above)
    );

    // Scan sequencer: stimulus stepping, capture, emission pointer, status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            settle_q <= '0;
            table_q  <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        table_q  <= '0;
                        count_q  <= '0;
                        idx_q    <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q       <= '0;
                        table_q[idx_q] <= s_in;
                        if (s_in == TARGET) begin
                            count_q <= count_q + (N_VARS+1)'(1);
                        end
                        if (idx_q == LAST_IDX) begin
                            ptr_q   <= '0;
                            state_q <= EMIT;
                        end else begin
                            idx_q <= idx_q + N_VARS'(1);
                        end
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                EMIT: begin
                    if (ptr_adv) begin
                        if (ptr_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            ptr_q <= ptr_q + N_VARS'(1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The stream outputs decode registered state only, so they hold steady
    // for a whole cycle and stay put while the consumer stalls.
    assign m_valid   = (state_q == EMIT) && hit;
    assign m_index   = ptr_q;
    assign m_last    = m_valid && !target_above;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_out   = idx_q;
    assign table_out = table_q;
    assign m_count   = count_q;

endmodule
